// File: rtl/codec_init_sequencer.sv
// rtl/codec_init_sequencer.sv - power-up codec register init and runtime write sequencer for i2cgenerator
module codec_init_sequencer #(
    parameter int NUM_WORDS      = 8,
    parameter int POWERUP_CYCLES = 50000,
    parameter int GAP_CYCLES     = 500
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    output logic        load,
    output logic [15:0] data,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        init_done,
    output logic        busy,
    output logic [3:0]  word_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POWERUP,
        S_ISSUE,
        S_HOLD,
        S_WAIT_RDY,
        S_GAP,
        S_DONE
    } state_t;

    // A zero delay parameter behaves like one cycle
    localparam logic [15:0] PU_TC    = 16'((POWERUP_CYCLES > 1) ? POWERUP_CYCLES - 1 : 0);
    localparam logic [15:0] GAP_TC   = 16'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]  LAST_IDX = 4'((NUM_WORDS > 1) ? NUM_WORDS - 1 : 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        init_done_q, init_done_d;
    logic        runtime_q, runtime_d;
    logic        start_q;
    logic [15:0] data_q;
    logic [15:0] word;

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0C10;
            4'd2:    return 16'h0812;
            4'd3:    return 16'h0A06;
            4'd4:    return 16'h0E42;
            4'd5:    return 16'h1000;
            4'd6:    return 16'h1201;
            4'd7:    return 16'h0C00;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 4'd0;
            init_done_q <= 1'b0;
            runtime_q   <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            runtime_q   <= runtime_d;
            start_q     <= start;
            data_q      <= word;
        end
    end

    // load is gated by ready in the same cycle, so it can never fire against a busy generator
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        runtime_d   = runtime_q;
        load        = 1'b0;
        cmd_ready   = 1'b0;
        word        = data_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 16'd0;
                state_d = S_POWERUP;
            end
            S_POWERUP: begin
                if (cnt_q == PU_TC) begin
                    cnt_d   = 16'd0;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ISSUE: begin
                if (ready) begin
                    load      = 1'b1;
                    word      = table_word(idx_q);
                    runtime_d = 1'b0;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (ready) begin
                    if (runtime_q) begin
                        state_d = S_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        init_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_TC) begin
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 4'd1;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                if (start && !start_q) begin
                    init_done_d = 1'b0;
                    idx_d       = 4'd0;
                    state_d     = S_ISSUE;
                end else if (cmd_valid && ready) begin
                    cmd_ready = 1'b1;
                    load      = 1'b1;
                    word      = cmd_data;
                    runtime_d = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = word;
    assign init_done = init_done_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign word_idx  = idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb/tb_codec_init_sequencer.sv - directed self-checking bench for codec_init_sequencer
module tb_codec_init_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data = 16'h0000;
    logic        load;
    logic [15:0] data;
    logic        cmd_ready;
    logic        init_done;
    logic        busy;
    logic [3:0]  word_idx;

    codec_init_sequencer #(
        .NUM_WORDS(8),
        .POWERUP_CYCLES(10),
        .GAP_CYCLES(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .start(start),
        .ready(ready),
        .load(load),
        .data(data),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .init_done(init_done),
        .busy(busy),
        .word_idx(word_idx)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic [15:0] tbl [8] = '{16'h1E00, 16'h0C10, 16'h0812, 16'h0A06,
                             16'h0E42, 16'h1000, 16'h1201, 16'h0C00};

    int          load_cyc [$];
    logic [15:0] load_dat [$];
    logic [3:0]  load_idx [$];
    int          cr_cyc [$];
    int          dbl = 0;
    int          lnr = 0;
    int          hv = 0;
    int          done_cyc = -1;
    logic        prev_load = 1'b0;
    logic        prev_reset = 1'b1;
    logic        prev_done = 1'b0;
    logic        neg_load = 1'b0;
    logic [15:0] last_data = 16'h0000;
    int          slow_n = 1;
    int          drop = 0;

    // Generator model: ready drops for slow_n cycles after each load
    initial forever begin
        @(posedge CLOCK_50);
        #1;
        if (reset) begin
            drop  = 0;
            ready = 1'b1;
        end else begin
            if (neg_load) drop = slow_n;
            if (drop > 0) begin
                ready = 1'b0;
                drop--;
            end else begin
                ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge CLOCK_50);
        #2;
        if (load) begin
            load_cyc.push_back(cyc);
            load_dat.push_back(data);
            load_idx.push_back(word_idx);
            if (prev_load) dbl++;
            if (!ready) lnr++;
        end
        if (!load && !reset && !prev_reset && data !== last_data) hv++;
        if (cmd_ready) cr_cyc.push_back(cyc);
        if (init_done && !prev_done) done_cyc = cyc;
        prev_load  = load;
        neg_load   = load;
        prev_reset = reset;
        prev_done  = init_done;
        last_data  = data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        load_cyc.delete();
        load_dat.delete();
        load_idx.delete();
        cr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (init_done !== 1'b1 && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        #3;
        chk("done_timeout", 32'(init_done), 32'd1);
    endtask

    task automatic check_walk(input string pfx, input int l0, input int spacing, input int nexp);
        chk({pfx, "_nloads"}, 32'(load_cyc.size()), 32'(nexp));
        for (int k = 0; k < 8; k++) begin
            if (k < load_cyc.size()) begin
                chk($sformatf("%s_data%0d", pfx, k), 32'(load_dat[k]), 32'(tbl[k]));
                chk($sformatf("%s_cyc%0d", pfx, k), 32'(load_cyc[k]), 32'(l0 + spacing * k));
                chk($sformatf("%s_idx%0d", pfx, k), 32'(load_idx[k]), 32'(k));
            end
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_load"}, 32'(load), 32'd0);
        chk({pfx, "_data"}, 32'(data), 32'd0);
        chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({pfx, "_init_done"}, 32'(init_done), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_word_idx"}, 32'(word_idx), 32'd0);
    endtask

    initial begin
        int r;
        int a;
        int s;
        int n;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #3;
        check_outputs_zero("rst");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        r = cyc;
        clear_log();

        // Power-up delay and full table walk, fast generator
        wait_done(200);
        check_walk("walk", r + 11, 7, 8);
        chk("walk_done_cyc", 32'(done_cyc), 32'(r + 63));
        chk("walk_final_idx", 32'(word_idx), 32'd7);
        chk("walk_idle_busy", 32'(busy), 32'd0);

        // Runtime write, valid held across two accepts
        clear_log();
        @(negedge CLOCK_50);
        cmd_data  = 16'h0408;
        cmd_valid = 1'b1;
        #1;
        a = cyc;
        chk("rt_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rt_load", 32'(load), 32'd1);
        chk("rt_data", 32'(data), 32'h0408);
        repeat (3) @(negedge CLOCK_50);
        #1;
        chk("rt2_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rt2_load", 32'(load), 32'd1);
        #2;
        chk("rt_accepts", 32'(cr_cyc.size()), 32'd2);
        if (cr_cyc.size() == 2) chk("rt_accept2_cyc", 32'(cr_cyc[1]), 32'(a + 3));
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;

        // Start rise and command in the same DONE cycle
        repeat (3) @(negedge CLOCK_50);
        clear_log();
        start     = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h1234;
        #1;
        s = cyc;
        chk("sc_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("sc_load", 32'(load), 32'd0);
        @(negedge CLOCK_50);
        #1;
        chk("sc_init_done_drop", 32'(init_done), 32'd0);
        chk("sc_first_load", 32'(load), 32'd1);
        chk("sc_first_data", 32'(data), 32'h1E00);
        wait_done(200);
        check_walk("rerun", s + 1, 7, 9);
        chk("rerun_done_cyc", 32'(done_cyc), 32'(s + 53));
        chk("rerun_accepts", 32'(cr_cyc.size()), 32'd1);
        if (cr_cyc.size() == 1) chk("rerun_accept_cyc", 32'(cr_cyc[0]), 32'(s + 53));
        if (load_dat.size() == 9) chk("rerun_cmd_data", 32'(load_dat[8]), 32'h1234);
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        start     = 1'b0;
        repeat (4) @(posedge CLOCK_50);

        // Slow generator after a fresh reset
        slow_n = 200;
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        r = cyc;
        clear_log();
        wait_done(2500);
        check_walk("slow", r + 11, 206, 8);
        chk("slow_done_cyc", 32'(done_cyc), 32'(r + 1655));

        // Reset during the gap after word 3
        slow_n = 1;
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        r = cyc;
        clear_log();
        n = 0;
        while (load_cyc.size() < 4 && n < 200) begin
            @(negedge CLOCK_50);
            #3;
            n++;
        end
        chk("mid_loads", 32'(load_cyc.size()), 32'd4);
        if (load_cyc.size() == 4) chk("mid_word3_cyc", 32'(load_cyc[3]), 32'(r + 32));
        repeat (3) @(negedge CLOCK_50);
        chk("mid_gap_busy", 32'(busy), 32'd1);
        chk("mid_gap_idx", 32'(word_idx), 32'd3);
        reset = 1'b1;
        @(negedge CLOCK_50);
        #3;
        check_outputs_zero("mid_rst");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        r = cyc;
        clear_log();
        n = 0;
        while (load_cyc.size() < 1 && n < 50) begin
            @(negedge CLOCK_50);
            #3;
            n++;
        end
        chk("restart_loads", 32'(load_cyc.size()), 32'd1);
        if (load_cyc.size() >= 1) begin
            chk("restart_cyc", 32'(load_cyc[0]), 32'(r + 11));
            chk("restart_data", 32'(load_dat[0]), 32'h1E00);
            chk("restart_idx", 32'(load_idx[0]), 32'd0);
        end

        // Handshake invariants over the whole run
        chk("double_load", 32'(dbl), 32'd0);
        chk("load_not_ready", 32'(lnr), 32'd0);
        chk("data_hold", 32'(hv), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
